// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the iterative unsigned divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_BPC   = 1;
  localparam int unsigned DEF_ITERS = DEF_WIDTH / DEF_BPC;
  localparam int unsigned DEF_CNT_W = $clog2(DEF_ITERS + 1);

  function automatic int unsigned iter_count(input int unsigned width, input int unsigned bpc);
    return width / bpc;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned iters);
    return $clog2(iters + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step built around a WIDTH+1-bit
// carry-lookahead subtractor (rem + ~divisor + 1).
module divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  localparam int unsigned W1 = WIDTH + 1;

  logic [W1-1:0] t;
  logic [W1-1:0] b_n;
  logic [W1-1:0] prop;
  logic [W1:0]   carry;
  logic [W1-1:0] diff;
  logic          no_borrow;

  assign t    = {rem_i, q_i[WIDTH-1]};
  assign b_n  = ~{1'b0, divisor_i};
  assign prop = t ^ b_n;

  // Parallel-prefix carry tree; the +1 carry-in is folded into bit 0's generate.
  always_comb begin
    logic [W1-1:0] g;
    logic [W1-1:0] p;
    logic [W1-1:0] g_nx;
    logic [W1-1:0] p_nx;
    g    = t & b_n;
    g[0] = g[0] | prop[0];
    p    = prop;
    for (int unsigned d = 1; d < W1; d = d * 2) begin
      g_nx = g;
      p_nx = p;
      for (int unsigned i = d; i < W1; i++) begin
        g_nx[i] = g[i] | (p[i] & g[i-d]);
        p_nx[i] = p[i] & p[i-d];
      end
      g = g_nx;
      p = p_nx;
    end
    carry = {g, 1'b1};
  end

  assign diff      = prop ^ carry[W1-1:0];
  assign no_borrow = carry[W1];

  assign rem_o = no_borrow ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_o   = {q_i[WIDTH-2:0], no_borrow};

endmodule

// File: rtl/divider_unsigned_iter.sv
// Iterative unsigned divider (DIVU/REMU) with valid/ready on both sides.
// Optional DIVIDER_ZERO_BYPASS_EN: divide-by-zero completes one clock after accept.
module divider_unsigned_iter
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH          = DEF_WIDTH,
  parameter int unsigned BITS_PER_CYCLE = DEF_BPC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned      N    = iter_count(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned      CW   = cnt_width(N);
  localparam logic [CW-1:0]    LAST = CW'(N - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] rem_c [0:BITS_PER_CYCLE];
  logic [WIDTH-1:0] q_c   [0:BITS_PER_CYCLE];

  assign rem_c[0] = rem_q;
  assign q_c[0]   = q_q;

  for (genvar s = 0; s < BITS_PER_CYCLE; s++) begin : g_step
    divider_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .rem_i    (rem_c[s]),
      .q_i      (q_c[s]),
      .divisor_i(div_q),
      .rem_o    (rem_c[s+1]),
      .q_o      (q_c[s+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    rem_d     = rem_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          div_d   = divisor;
          q_d     = dividend;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef DIVIDER_ZERO_BYPASS_EN
          if (divisor == '0) begin
            q_d     = '1;
            rem_d   = dividend;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        q_d   = q_c[BITS_PER_CYCLE];
        rem_d = rem_c[BITS_PER_CYCLE];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  assign quotient  = q_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_divider_unsigned_iter.sv
// Directed-vector bench for divider_unsigned_iter at BITS_PER_CYCLE 1 and 4.
module tb_divider_unsigned_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        iv_a = 1'b0, ir_a, ov_a, or_a = 1'b0;
  logic [31:0] dd_a = '0, dv_a = '0, q_a, r_a;
  logic        iv_b = 1'b0, ir_b, ov_b, or_b = 1'b0;
  logic [31:0] dd_b = '0, dv_b = '0, q_b, r_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider_unsigned_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
    .dividend(dd_a), .divisor(dv_a), .out_valid(ov_a), .out_ready(or_a),
    .quotient(q_a), .remainder(r_a)
  );

  divider_unsigned_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
    .dividend(dd_b), .divisor(dv_b), .out_valid(ov_b), .out_ready(or_b),
    .quotient(q_b), .remainder(r_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b, input int n);
`ifdef DIVIDER_ZERO_BYPASS_EN
    if (b == 32'd0) return 1;
`endif
    return n + 1;
  endfunction

  // Latency counts the accept edge as edge 1.
  task automatic issue_a(input logic [31:0] a, input logic [31:0] b, output int lat);
    int guard;
    @(negedge clk);
    dd_a = a; dv_a = b; iv_a = 1'b1;
    guard = 0;
    while (!ir_a && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    iv_a = 1'b0;
    lat = 1;
    while (!ov_a && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume_a();
    @(negedge clk); or_a = 1'b1;
    @(posedge clk); #1; or_a = 1'b0;
  endtask

  task automatic issue_b(input logic [31:0] a, input logic [31:0] b, output int lat);
    int guard;
    @(negedge clk);
    dd_b = a; dv_b = b; iv_b = 1'b1;
    guard = 0;
    while (!ir_b && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    iv_b = 1'b0;
    lat = 1;
    while (!ov_b && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume_b();
    @(negedge clk); or_b = 1'b1;
    @(posedge clk); #1; or_b = 1'b0;
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [31:0] vq [8];
  logic [31:0] vr [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] a, b, eq, er;

    va = '{32'd100,        32'hFFFF_FFFF, 32'h8000_0000, 32'd1234,
           32'hFFFF_FFFF,  32'd7,         32'hFFFF_FFFF, 32'd1000000};
    vb = '{32'd7,          32'd1,         32'hFFFF_FFFF, 32'd0,
           32'hFFFF_FFFF,  32'd100,       32'h10,        32'd3};
    vq = '{32'd14,         32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF,
           32'd1,          32'd0,         32'h0FFF_FFFF, 32'd333333};
    vr = '{32'd2,          32'd0,         32'h8000_0000, 32'd1234,
           32'd0,          32'd7,         32'hF,         32'd1};

    repeat (3) @(negedge clk);
    check("rst_quot",  q_a, 32'd0);
    check("rst_rem",   r_a, 32'd0);
    check("rst_ovld",  {31'd0, ov_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_irdy",  {31'd0, ir_a}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      issue_a(va[i], vb[i], lat);
      check($sformatf("bpc1_q[%0d]", i), q_a, vq[i]);
      check($sformatf("bpc1_r[%0d]", i), r_a, vr[i]);
      check($sformatf("bpc1_lat[%0d]", i), 32'(lat), 32'(exp_lat(vb[i], 32)));
      consume_a();
    end

    // Hold the result in DONE while fresh operands are offered; they must wait.
    issue_a(32'd50000, 32'd123, lat);
    @(negedge clk);
    dd_a = 32'd5; dv_a = 32'd1; iv_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_q",    q_a, 32'd406);
      check("hold_r",    r_a, 32'd62);
      check("hold_ovld", {31'd0, ov_a}, 32'd1);
      check("hold_irdy", {31'd0, ir_a}, 32'd0);
    end
    iv_a = 1'b0;
    consume_a();
    check("rel_irdy", {31'd0, ir_a}, 32'd1);
    check("rel_ovld", {31'd0, ov_a}, 32'd0);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    dd_a = 32'hDEAD_BEEF; dv_a = 32'h1234; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_ovld", {31'd0, ov_a}, 32'd0);
    check("mrst_q",    q_a, 32'd0);
    check("mrst_r",    r_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_irdy", {31'd0, ir_a}, 32'd1);
    issue_a(32'd9, 32'd3, lat);
    check("post_rst_q", q_a, 32'd3);
    check("post_rst_r", r_a, 32'd0);
    check("post_rst_lat", 32'(lat), 32'd33);
    consume_a();

    for (int i = 0; i < 8; i++) begin
      issue_b(va[i], vb[i], lat);
      check($sformatf("bpc4_q[%0d]", i), q_b, vq[i]);
      check($sformatf("bpc4_r[%0d]", i), r_b, vr[i]);
      check($sformatf("bpc4_lat[%0d]", i), 32'(lat), 32'(exp_lat(vb[i], 8)));
      consume_b();
    end

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = $urandom_range(1, 255);
        1:       b = $urandom >> $urandom_range(0, 31);
        2:       b = a >> $urandom_range(0, 8);
        default: b = $urandom;
      endcase
      eq = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      er = (b == 32'd0) ? a : a % b;
      issue_b(a, b, lat);
      check($sformatf("rnd_q[%0d]", i), q_b, eq);
      check($sformatf("rnd_r[%0d]", i), r_b, er);
      check($sformatf("rnd_lat[%0d]", i), 32'(lat), 32'(exp_lat(b, 8)));
      consume_b();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
